// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register through a one-entry skid buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN (adds the fetch_fault output).
module fetch_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             id_stall,
   output logic             id_valid,
   output logic [WIDTH-1:0] id_instr,
   output logic [WIDTH-1:0] id_pc,
   output logic [WIDTH-1:0] id_pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
   ,output logic            fetch_fault
`endif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             skid_valid_q;
   logic [WIDTH-1:0] skid_instr_q, skid_pc_q;
   logic [WIDTH-1:0] redirect_tgt;
   logic             fetch_blocked;
   logic             grant, rsp_wait, slot_free;

`ifdef FETCH_MISALIGN_CHK_EN
   logic fault_q;

   assign redirect_tgt  = redirect_pc;
   assign fetch_blocked = fault_q;
   assign fetch_fault   = fault_q;

   // Fault latches on any misaligned redirect and clears only on an aligned one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              fault_q <= 1'b0;
      else if (redirect_valid) fault_q <= |redirect_pc[1:0];
   end
`else
   assign redirect_tgt  = redirect_pc & ~(WIDTH'(3));
   assign fetch_blocked = 1'b0;
`endif

   assign imem_req  = (state_q == S_REQ) && !skid_valid_q && !fetch_blocked;
   assign imem_addr = pc_q;
   assign grant     = imem_req && imem_gnt;
   assign rsp_wait  = (state_q == S_WAIT) && imem_rvalid;
   assign slot_free = !id_valid || !id_stall;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_REQ:   if (grant) state_d = S_WAIT;
         S_WAIT:  if (imem_rvalid) begin
                     state_d = S_REQ;
                     pc_d    = pc_q + WIDTH'(4);
                  end
         S_DRAIN: if (imem_rvalid) state_d = S_REQ;
         default: state_d = S_REQ;
      endcase
      if (redirect_valid) begin
         pc_d = redirect_tgt;
         // A request already accepted for the old path must have its response drained.
         case (state_q)
            S_REQ:   state_d = grant ? S_DRAIN : S_REQ;
            S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid     <= 1'b0;
         id_instr     <= '0;
         id_pc        <= '0;
         id_pc_plus4  <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else if (redirect_valid) begin
         id_valid     <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (slot_free) begin
         if (skid_valid_q) begin
            id_valid     <= 1'b1;
            id_instr     <= skid_instr_q;
            id_pc        <= skid_pc_q;
            id_pc_plus4  <= skid_pc_q + WIDTH'(4);
            skid_valid_q <= 1'b0;
         end else if (rsp_wait) begin
            id_valid    <= 1'b1;
            id_instr    <= imem_rdata;
            id_pc       <= pc_q;
            id_pc_plus4 <= pc_q + WIDTH'(4);
         end else begin
            id_valid <= 1'b0;
         end
      end else if (rsp_wait) begin
         // Decode is holding: park the response until the stall releases.
         skid_valid_q <= 1'b1;
         skid_instr_q <= imem_rdata;
         skid_pc_q    <= pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset/fault sequences, and a randomized
// run scored against an in-order instruction-stream model. Honors FETCH_MISALIGN_CHK_EN.
module tb_fetch_stage;

   localparam int W = 32;
   localparam logic [W-1:0] RST_PC = 32'h0000_0000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic         imem_gnt;
   logic         imem_rvalid;
   logic [W-1:0] imem_rdata;
   logic         redirect_valid;
   logic [W-1:0] redirect_pc;
   logic         id_stall;
   logic         id_valid;
   logic [W-1:0] id_instr, id_pc, id_pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
   logic         fetch_fault;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.WIDTH(W), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
      , .fetch_fault(fetch_fault)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Memory contents: a fixed scramble of the address.
   function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   typedef struct {
      logic         gnt, rvalid, stall, redir;
      logic [W-1:0] rd_addr, rpc;
      logic         e_req;
      logic [W-1:0] e_addr;
      logic         e_valid;
      logic [W-1:0] e_pc;
   } vec_t;

   function automatic vec_t mk(input logic g, input logic rv, input logic [W-1:0] ra, input logic st,
                               input logic rd, input logic [W-1:0] rp, input logic er,
                               input logic [W-1:0] ea, input logic ev, input logic [W-1:0] ep);
      vec_t v;
      v.gnt = g; v.rvalid = rv; v.rd_addr = ra; v.stall = st; v.redir = rd; v.rpc = rp;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
      return v;
   endfunction

   task automatic drive(input logic g, input logic rv, input logic [W-1:0] rd, input logic st,
                        input logic rdr, input logic [W-1:0] rp);
      imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_stall = st;
      redirect_valid = rdr; redirect_pc = rp;
   endtask

   // Apply one cycle of inputs, then return at the following falling edge.
   task automatic cyc(input logic g, input logic rv, input logic [W-1:0] rd, input logic st,
                      input logic rdr, input logic [W-1:0] rp);
      drive(g, rv, rd, st, rdr, rp);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(0, 0, '0, 0, 0, '0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("first_req", imem_req, 1'b1);
      check("first_addr", imem_addr, RST_PC);
      check("reset_id_valid", id_valid, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
      check("reset_fault", fetch_fault, 1'b0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   vec_t         tbl[25];
   logic         pend_valid;
   logic [W-1:0] pend_addr;
   int           pend_cnt;
   logic [W-1:0] exp_pc;
   int           consumed;

   initial begin
      tbl[0]  = mk(1, 0, 0,      0, 0, 0,      0, 32'h000, 0, 0);
      tbl[1]  = mk(0, 1, 32'h0,  0, 0, 0,      1, 32'h004, 1, 32'h000);
      tbl[2]  = mk(1, 0, 0,      0, 0, 0,      0, 32'h004, 0, 0);
      tbl[3]  = mk(0, 1, 32'h4,  0, 0, 0,      1, 32'h008, 1, 32'h004);
      tbl[4]  = mk(1, 0, 0,      1, 0, 0,      0, 32'h008, 1, 32'h004);
      tbl[5]  = mk(0, 1, 32'h8,  1, 0, 0,      0, 32'h00C, 1, 32'h004);
      tbl[6]  = mk(1, 0, 0,      1, 0, 0,      0, 32'h00C, 1, 32'h004);
      tbl[7]  = mk(1, 0, 0,      1, 0, 0,      0, 32'h00C, 1, 32'h004);
      tbl[8]  = mk(1, 0, 0,      1, 0, 0,      0, 32'h00C, 1, 32'h004);
      tbl[9]  = mk(0, 0, 0,      0, 0, 0,      1, 32'h00C, 1, 32'h008);
      tbl[10] = mk(1, 0, 0,      0, 0, 0,      0, 32'h00C, 0, 0);
      tbl[11] = mk(0, 0, 0,      0, 1, 32'h100, 0, 32'h100, 0, 0);
      tbl[12] = mk(0, 1, 32'hC,  0, 0, 0,      1, 32'h100, 0, 0);
      tbl[13] = mk(1, 0, 0,      0, 0, 0,      0, 32'h100, 0, 0);
      tbl[14] = mk(0, 1, 32'h100, 0, 0, 0,     1, 32'h104, 1, 32'h100);
      tbl[15] = mk(1, 0, 0,      0, 0, 0,      0, 32'h104, 0, 0);
      tbl[16] = mk(0, 1, 32'h104, 0, 1, 32'h200, 1, 32'h200, 0, 0);
      tbl[17] = mk(0, 0, 0,      0, 0, 0,      1, 32'h200, 0, 0);
      tbl[18] = mk(1, 0, 0,      0, 1, 32'h300, 0, 32'h300, 0, 0);
      tbl[19] = mk(0, 0, 0,      0, 1, 32'h400, 0, 32'h400, 0, 0);
      tbl[20] = mk(0, 1, 32'h200, 0, 0, 0,     1, 32'h400, 0, 0);
      tbl[21] = mk(1, 0, 0,      0, 0, 0,      0, 32'h400, 0, 0);
      tbl[22] = mk(0, 1, 32'h400, 1, 0, 0,     1, 32'h404, 1, 32'h400);
      tbl[23] = mk(0, 0, 0,      1, 1, 32'h500, 1, 32'h500, 0, 0);
      tbl[24] = mk(0, 0, 0,      0, 0, 0,      1, 32'h500, 0, 0);

      // Directed vector table: inputs for one cycle, outputs expected after that edge.
      do_reset();
      for (int i = 0; i < 25; i++) begin
         cyc(tbl[i].gnt, tbl[i].rvalid, tbl[i].rvalid ? instr_of(tbl[i].rd_addr) : 32'hBAD0_BAD0,
             tbl[i].stall, tbl[i].redir, tbl[i].rpc);
         check($sformatf("vec%0d_req", i), imem_req, tbl[i].e_req);
         check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
         check($sformatf("vec%0d_valid", i), id_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            check($sformatf("vec%0d_pc", i), id_pc, tbl[i].e_pc);
            check($sformatf("vec%0d_instr", i), id_instr, instr_of(tbl[i].e_pc));
            check($sformatf("vec%0d_pc4", i), id_pc_plus4, tbl[i].e_pc + 32'd4);
         end
      end

      // Reset asserted mid-WAIT with a valid, stalled IF/ID entry.
      do_reset();
      cyc(1, 0, '0, 0, 0, '0);
      cyc(0, 1, instr_of(32'h0), 0, 0, '0);
      cyc(1, 0, '0, 1, 0, '0);
      check("pre_rst_valid", id_valid, 1'b1);
      check("pre_rst_req", imem_req, 1'b0);
      #2 rst_n = 1'b0;
      drive(0, 0, '0, 0, 0, '0);
      #1;
      check("rst_async_valid", id_valid, 1'b0);
      check("rst_async_instr", id_instr, '0);
      check("rst_async_pc", id_pc, '0);
      check("rst_async_pc4", id_pc_plus4, '0);
      check("rst_async_addr", imem_addr, RST_PC);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_rel_req", imem_req, 1'b1);
      check("rst_rel_addr", imem_addr, RST_PC);
      cyc(1, 0, '0, 0, 0, '0);
      cyc(0, 1, instr_of(RST_PC), 0, 0, '0);
      check("rst_first_valid", id_valid, 1'b1);
      check("rst_first_pc", id_pc, RST_PC);

      // Misaligned redirect handling.
      do_reset();
`ifdef FETCH_MISALIGN_CHK_EN
      cyc(0, 0, '0, 0, 1, 32'h102);
      check("mis_fault_set", fetch_fault, 1'b1);
      check("mis_no_req", imem_req, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, '0, 0, 0, '0);
         check($sformatf("mis_hold_req%0d", i), imem_req, 1'b0);
         check($sformatf("mis_hold_fault%0d", i), fetch_fault, 1'b1);
      end
      cyc(0, 0, '0, 0, 1, 32'h200);
      check("mis_fault_clr", fetch_fault, 1'b0);
      check("mis_resume_req", imem_req, 1'b1);
      check("mis_resume_addr", imem_addr, 32'h200);
      cyc(1, 0, '0, 0, 0, '0);
      cyc(0, 1, instr_of(32'h200), 0, 0, '0);
      check("mis_resume_valid", id_valid, 1'b1);
      check("mis_resume_pc", id_pc, 32'h200);
`else
      cyc(0, 0, '0, 0, 1, 32'h102);
      check("mask_req", imem_req, 1'b1);
      check("mask_addr", imem_addr, 32'h100);
      cyc(1, 0, '0, 0, 0, '0);
      cyc(0, 1, instr_of(32'h100), 0, 0, '0);
      check("mask_pc", id_pc, 32'h100);
      check("mask_pc4", id_pc_plus4, 32'h104);
`endif

      // Randomized run: every instruction decode consumes must be the next one in program order.
      do_reset();
      pend_valid = 1'b0; pend_addr = '0; pend_cnt = 0;
      exp_pc = RST_PC; consumed = 0;
      for (int c = 0; c < 3000; c++) begin
         logic         rv_now, g, st, rd, hs;
         logic [W-1:0] rp;
         rv_now = pend_valid && (pend_cnt == 0);
         g  = ($urandom_range(0, 9) < 7);
         st = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 31) == 0);
`ifdef FETCH_MISALIGN_CHK_EN
         rp = $urandom() & 32'h0000_FFFC;
`else
         rp = $urandom() & 32'h0000_FFFF;
`endif
         drive(g, rv_now, rv_now ? instr_of(pend_addr) : $urandom(), st, rd, rp);
         #1;
         hs = imem_req && imem_gnt;
         if (hs) check("single_outstanding", pend_valid, 1'b0);
         if (id_valid && !id_stall) begin
            check("rnd_pc", id_pc, exp_pc);
            check("rnd_instr", id_instr, instr_of(exp_pc));
            check("rnd_pc4", id_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (rd) exp_pc = rp & ~32'd3;
         if (rv_now) pend_valid = 1'b0;
         else if (pend_valid) pend_cnt--;
         if (hs) begin
            pend_valid = 1'b1;
            pend_addr  = imem_addr;
            pend_cnt   = $urandom_range(0, 2);
         end
         @(negedge clk);
      end
      check("rnd_progress", (consumed > 200) ? 1'b1 : 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
